cla_serial_adder: RTL and testbench

Multi-cycle adder/subtractor controller that runs a WIDTH-bit add or subtract through a single `cla_4bit` slice, one nibble per clock. It sits in the MIPS ALU path as a low-area alternative to a full-width carry-lookahead adder. It owns the sequencing, the carry chain register, operand/result shifting and flag generation. Operands enter and results leave through valid/ready handshakes.

---
 rtl/cla_seq_pkg.sv | 8 +
 rtl/cla_4bit.sv | 30 +++
 rtl/cla_serial_adder.sv | 117 +++++++++++
 tb/tb_cla_serial_adder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_seq_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder controller.
package cla_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} cla_seq_state_t;

    localparam int unsigned NIBBLE_W = 4;

endpackage

// File: rtl/cla_4bit.sv
// Combinational 4-bit carry-lookahead adder slice.
module cla_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       c_in,
    output logic       c_out,
    output logic [3:0] Sum
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = A & B;
    assign w_p = A ^ B;

    // Every carry is a flat sum-of-products of generate/propagate terms.
    assign w_c[0] = c_in;
    assign w_c[1] = w_g[0] | (w_p[0] & c_in);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c_in);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & c_in);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & c_in);

    assign Sum   = w_p ^ w_c[3:0];
    assign c_out = w_c[4];

endmodule

// File: rtl/cla_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one nibble per clock through a single cla_4bit slice,
// operands and results exchanged over valid/ready handshakes.
module cla_serial_adder
    import cla_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int unsigned N     = WIDTH / NIBBLE_W;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    cla_seq_state_t     r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum_sh;
    logic               r_carry;
    logic               r_a_msb;
    logic               r_b_msb;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_c_out;
    logic               r_overflow;

    logic [WIDTH-1:0]    w_b_eff;
    logic [NIBBLE_W-1:0] w_slice_sum;
    logic                w_slice_cout;
    logic [WIDTH-1:0]    w_sum_next;

    assign w_b_eff = sub ? ~b : b;

    cla_4bit u_slice (
        .A     (r_a_sh[NIBBLE_W-1:0]),
        .B     (r_b_sh[NIBBLE_W-1:0]),
        .c_in  (r_carry),
        .c_out (w_slice_cout),
        .Sum   (w_slice_sum)
    );

    // Result nibbles enter at the top so the LSB nibble lands at the bottom after N steps.
    if (N > 1) begin : g_sum_shift
        assign w_sum_next = {w_slice_sum, r_sum_sh[WIDTH-1:NIBBLE_W]};
    end else begin : g_sum_single
        assign w_sum_next = w_slice_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_sum_sh   <= '0;
            r_carry    <= 1'b0;
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_c_out    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sh  <= a;
                        r_b_sh  <= w_b_eff;
                        r_carry <= sub ? 1'b1 : c_in;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= w_b_eff[WIDTH-1];
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a_sh   <= r_a_sh >> NIBBLE_W;
                    r_b_sh   <= r_b_sh >> NIBBLE_W;
                    r_sum_sh <= w_sum_next;
                    r_carry  <= w_slice_cout;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    // Outputs are captured once so they stay frozen for the whole DONE period.
                    if (r_cnt == CNT_W'(N - 1)) begin
                        r_state    <= DONE;
                        r_sum      <= w_sum_next;
                        r_c_out    <= w_slice_cout;
                        r_overflow <= (r_a_msb == r_b_msb)
                                    && (w_slice_sum[NIBBLE_W-1] != r_a_msb);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign c_out     = r_c_out;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_cla_serial_adder.sv
// Self-checking bench: directed WIDTH=32 scenarios plus a WIDTH=8 back-to-back scoreboard run.
module tb_cla_serial_adder;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid32 = 1'b0, out_ready32 = 1'b0, c_in32 = 1'b0, sub32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        in_ready32, out_valid32, c_out32, ovf32;
    logic [31:0] sum32;

    logic        in_valid8 = 1'b0, out_ready8 = 1'b0, c_in8 = 1'b0, sub8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        in_ready8, out_valid8, c_out8, ovf8;
    logic [7:0]  sum8;

    exp_t sb32[$];
    exp_t sb8[$];

    int n_checks = 0;
    int n_pass   = 0;

    cla_serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .c_in(c_in32), .sub(sub32), .out_valid(out_valid32),
        .out_ready(out_ready32), .sum(sum32), .c_out(c_out32), .overflow(ovf32)
    );

    cla_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .c_in(c_in8), .sub(sub8), .out_valid(out_valid8),
        .out_ready(out_ready8), .sum(sum8), .c_out(c_out8), .overflow(ovf8)
    );

    // Reference arithmetic for a w-bit operation held in the low bits of 32-bit words.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub, input int w);
        exp_t        r;
        logic [32:0] full;
        logic [31:0] mask;
        logic [31:0] beff;
        mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        beff   = (sub ? ~b : b) & mask;
        full   = {1'b0, a & mask} + {1'b0, beff} + {32'd0, (sub ? 1'b1 : cin)};
        r.sum  = full[31:0] & mask;
        r.cout = full[w];
        r.ovf  = (a[w-1] == beff[w-1]) && (r.sum[w-1] != a[w-1]);
        return r;
    endfunction

    task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic cin,
                           input logic sub, input exp_t exp);
        @(negedge clk);
        in_valid32 = 1'b1;
        a32 = a; b32 = b; c_in32 = cin; sub32 = sub;
        sb32.push_back(exp);
        @(negedge clk);
        in_valid32 = 1'b0;
    endtask

    task automatic wait_done32(output int lat);
        lat = 0;
        while (!out_valid32 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release32();
        out_ready32 = 1'b1;
        @(negedge clk);
        out_ready32 = 1'b0;
    endtask

    task automatic check_result32(input string name);
        exp_t e;
        n_checks++;
        if (sb32.size() == 0) begin
            $display("FAIL %s: scoreboard empty, observed sum=%h", name, sum32);
            return;
        end
        e = sb32.pop_front();
        if (sum32 !== e.sum || c_out32 !== e.cout || ovf32 !== e.ovf || out_valid32 !== 1'b1)
            $display("FAIL %s: got valid=%b sum=%h c_out=%b ovf=%b, want valid=1 sum=%h c_out=%b ovf=%b",
                     name, out_valid32, sum32, c_out32, ovf32, e.sum, e.cout, e.ovf);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({in_ready32, out_valid32, sum32, c_out32, ovf32} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0})
            $display("FAIL reset32: got in_ready=%b out_valid=%b sum=%h c_out=%b ovf=%b, want 1 0 0 0 0",
                     in_ready32, out_valid32, sum32, c_out32, ovf32);
        else n_pass++;
        n_checks++;
        if ({in_ready8, out_valid8, sum8, c_out8, ovf8} !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0})
            $display("FAIL reset8: got in_ready=%b out_valid=%b sum=%h c_out=%b ovf=%b, want 1 0 0 0 0",
                     in_ready8, out_valid8, sum8, c_out8, ovf8);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_add_wrap();
        int lat;
        start32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b0});
        wait_done32(lat);
        n_checks++;
        if (lat !== 8) $display("FAIL latency_wrap: got %0d cycles, want 8", lat);
        else n_pass++;
        check_result32("add_wrap");
        release32();
    endtask

    task automatic test_overflow();
        int lat;
        start32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1});
        wait_done32(lat);
        n_checks++;
        if (lat !== 8) $display("FAIL latency_ovf: got %0d cycles, want 8", lat);
        else n_pass++;
        check_result32("signed_overflow");
        release32();
    endtask

    task automatic test_subtract();
        int lat;
        start32(32'd5, 32'd7, 1'b1, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0});
        wait_done32(lat);
        check_result32("sub_5_minus_7");
        release32();
        start32(32'd7, 32'd5, 1'b1, 1'b1, '{32'h0000_0002, 1'b1, 1'b0});
        wait_done32(lat);
        check_result32("sub_7_minus_5");
        release32();
        start32(32'h8000_0000, 32'd1, 1'b1, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1});
        wait_done32(lat);
        check_result32("sub_min_minus_1");
        release32();
    endtask

    task automatic test_backpressure();
        int lat;
        start32(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 1'b0, '{32'h1010_1011, 1'b0, 1'b0});
        wait_done32(lat);
        check_result32("bp_first");
        for (int i = 0; i < 5; i++) begin
            in_valid32 = 1'b1;
            a32 = $urandom; b32 = $urandom; sub32 = i[0];
            @(negedge clk);
            n_checks++;
            if ({in_ready32, out_valid32, sum32, c_out32, ovf32} !== {1'b0, 1'b1, 32'h1010_1011, 1'b0, 1'b0})
                $display("FAIL bp_hold%0d: got in_ready=%b out_valid=%b sum=%h c_out=%b ovf=%b, want 0 1 10101011 0 0",
                         i, in_ready32, out_valid32, sum32, c_out32, ovf32);
            else n_pass++;
        end
        in_valid32 = 1'b0;
        release32();
        n_checks++;
        if (in_ready32 !== 1'b1 || out_valid32 !== 1'b0)
            $display("FAIL bp_release: got in_ready=%b out_valid=%b, want 1 0", in_ready32, out_valid32);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (in_ready32 !== 1'b1)
            $display("FAIL bp_no_accept: got in_ready=%b, want 1 (no stray operation)", in_ready32);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int lat;
        // Aborted operation: driven without a scoreboard entry.
        @(negedge clk);
        in_valid32 = 1'b1;
        a32 = 32'hDEAD_BEEF; b32 = 32'hCAFE_F00D; c_in32 = 1'b1; sub32 = 1'b0;
        @(negedge clk);
        in_valid32 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({out_valid32, in_ready32, sum32, c_out32, ovf32} !== {1'b0, 1'b1, 32'd0, 1'b0, 1'b0})
            $display("FAIL reset_mid_run: got out_valid=%b in_ready=%b sum=%h c_out=%b ovf=%b, want 0 1 0 0 0",
                     out_valid32, in_ready32, sum32, c_out32, ovf32);
        else n_pass++;
        start32(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, '{32'h2345_6789, 1'b0, 1'b0});
        wait_done32(lat);
        n_checks++;
        if (lat !== 8) $display("FAIL latency_after_reset: got %0d cycles, want 8", lat);
        else n_pass++;
        check_result32("after_reset");
        release32();
    endtask

    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                           input logic sub);
        exp_t e;
        int   lat;
        @(negedge clk);
        n_checks++;
        if (in_ready8 !== 1'b1) $display("FAIL b2b_in_ready: got %b, want 1", in_ready8);
        else n_pass++;
        in_valid8 = 1'b1;
        a8 = a; b8 = b; c_in8 = cin; sub8 = sub;
        sb8.push_back(model({24'd0, a}, {24'd0, b}, cin, sub, 8));
        @(negedge clk);
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat !== 2) $display("FAIL b2b_latency a=%h b=%h: got %0d cycles, want 2", a, b, lat);
        else n_pass++;
        e = sb8.pop_front();
        n_checks++;
        if ({c_out8, sum8} !== {e.cout, e.sum[7:0]} || ovf8 !== e.ovf)
            $display("FAIL b2b_result a=%h b=%h cin=%b sub=%b: got c_out=%b sum=%h ovf=%b, want c_out=%b sum=%h ovf=%b",
                     a, b, cin, sub, c_out8, sum8, ovf8, e.cout, e.sum[7:0], e.ovf);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] corners [9];
        corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF, 8'h55, 8'hAA};
        out_ready8 = 1'b1;
        foreach (corners[i])
            foreach (corners[j])
                for (int m = 0; m < 4; m++)
                    run_op8(corners[i], corners[j], m[0], m[1]);
        for (int k = 0; k < 1500; k++)
            run_op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        out_ready8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_overflow();
        test_subtract();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
